// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : dmem_responder_pkg
// Brief   : funct3 width codes, responder state encoding, access-error rule
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package dmem_responder_pkg;

    localparam logic [2:0] c_F3_LB  = 3'd0;
    localparam logic [2:0] c_F3_LH  = 3'd1;
    localparam logic [2:0] c_F3_LW  = 3'd2;
    localparam logic [2:0] c_F3_LBU = 3'd4;
    localparam logic [2:0] c_F3_LHU = 3'd5;
    localparam logic [2:0] c_F3_SB  = 3'd0;
    localparam logic [2:0] c_F3_SH  = 3'd1;
    localparam logic [2:0] c_F3_SW  = 3'd2;

    localparam int unsigned c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] dmem_state_t;

    localparam dmem_state_t c_S_IDLE  = 3'd0;
    localparam dmem_state_t c_S_READ  = 3'd1;
    localparam dmem_state_t c_S_MERGE = 3'd2;
    localparam dmem_state_t c_S_WRITE = 3'd3;
    localparam dmem_state_t c_S_RESP  = 3'd4;

    // funct3[1:0] carries the access size for both loads and stores.
    function automatic logic f_access_err(input logic       write,
                                          input logic [2:0] funct3,
                                          input logic [1:0] lane);
        logic illegal;
        logic misaligned;
        if (write)
            illegal = (funct3 > c_F3_SW);
        else
            illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        misaligned = ((funct3[1:0] == 2'b01) && lane[0]) ||
                     ((funct3[1:0] == 2'b10) && (lane != 2'b00));
        return illegal || misaligned;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_sram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : dmem_sram
// Brief   : single-port word-wide synchronous RAM, read-first, 1-cycle read
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module dmem_sram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we)
            r_mem[addr] <= wdata;
        rdata <= r_mem[addr];
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : dmem_responder
// Brief   : load/store responder with read-modify-write sub-word stores
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    dmem_state_t           r_state;
    dmem_state_t           w_state_nxt;
    logic                  r_write;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_req_err;
    logic                  w_ram_we;
    logic [31:0]           w_ram_wdata;
    logic [31:0]           w_ram_rdata;
    logic                  w_unused_addr;

    function automatic logic [31:0] f_lane_extract(input logic [31:0] word,
                                                   input logic [2:0]  funct3,
                                                   input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            c_F3_LB:  res = {{24{b[7]}}, b};
            c_F3_LH:  res = {{16{h[15]}}, h};
            c_F3_LW:  res = word;
            c_F3_LBU: res = {24'd0, b};
            c_F3_LHU: res = {16'd0, h};
            default:  res = 32'd0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] f_lane_merge(input logic [31:0] word,
                                                 input logic [31:0] wdata,
                                                 input logic [2:0]  funct3,
                                                 input logic [1:0]  lane);
        logic [31:0] res;
        res = word;
        if (funct3 == c_F3_SB)
            res[{lane, 3'b000} +: 8] = wdata[7:0];
        else if (funct3 == c_F3_SH) begin
            if (lane[1])
                res[31:16] = wdata[15:0];
            else
                res[15:0] = wdata[15:0];
        end
        return res;
    endfunction

    assign w_accept      = req_valid && req_ready;
    assign w_req_err     = f_access_err(req_write, req_funct3, req_addr[1:0]);
    assign w_unused_addr = ^req_addr[31:ADDR_WIDTH+2];

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= c_S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_write  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_write  <= req_write;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr[ADDR_WIDTH+1:0];
            r_wdata  <= req_wdata;
            r_err    <= w_req_err;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    if (w_req_err)
                        w_state_nxt = c_S_RESP;
                    else if (req_write && (req_funct3 == c_F3_SW))
                        w_state_nxt = c_S_WRITE;
                    else
                        w_state_nxt = c_S_READ;
                end
            end
            c_S_READ:  w_state_nxt = r_write ? c_S_MERGE : c_S_RESP;
            c_S_MERGE: w_state_nxt = c_S_RESP;
            c_S_WRITE: w_state_nxt = c_S_RESP;
            c_S_RESP:  w_state_nxt = c_S_IDLE;
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    // Reset wins over an in-flight write so an abandoned store leaves RAM intact.
    always_comb begin
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_rdata  = 32'd0;
        resp_err    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_wdata = r_wdata;
        case (r_state)
            c_S_IDLE:  req_ready = !rst;
            c_S_WRITE: w_ram_we = !rst;
            c_S_MERGE: begin
                w_ram_we    = !rst;
                w_ram_wdata = f_lane_merge(w_ram_rdata, r_wdata, r_funct3, r_addr[1:0]);
            end
            c_S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                if (!r_err && !r_write)
                    resp_rdata = f_lane_extract(w_ram_rdata, r_funct3, r_addr[1:0]);
            end
            default: ;
        endcase
    end

    dmem_sram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (r_addr[ADDR_WIDTH+1:2]),
        .wdata (w_ram_wdata),
        .rdata (w_ram_rdata)
    );

endmodule
`default_nettype wire
